// File: rtl/gate_check_pkg.sv
// Shared types and the reference gate function
// for the exhaustive gate sweep checker.
package gate_check_pkg;

  typedef enum logic [2:0] {
    GF_NOR,
    GF_OR,
    GF_NAND,
    GF_AND,
    GF_XOR,
    GF_XNOR
  } gate_func_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam int MAX_IN     = 6;
  localparam int MAX_SETTLE = 15;

  function automatic logic expected_out(
    gate_func_e f,
    logic [5:0] v,
    int         n
  );
    logic r_or;
    logic r_and;
    logic r_xor;
    logic r;
    r_or  = 1'b0;
    r_and = 1'b1;
    r_xor = 1'b0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n) begin
        r_or  = r_or | v[i];
        r_and = r_and & v[i];
        r_xor = r_xor ^ v[i];
      end
    end
    unique case (f)
      GF_NOR:  r = ~r_or;
      GF_OR:   r = r_or;
      GF_NAND: r = ~r_and;
      GF_AND:  r = r_and;
      GF_XOR:  r = r_xor;
      GF_XNOR: r = ~r_xor;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_sweep_checker.sv
// Drives every input vector into a gate, samples its
// output after a settle time and tallies mismatches.
module gate_sweep_checker
  import gate_check_pkg::*;
#(
  parameter int         N_IN          = 2,
  parameter int         SETTLE_CYCLES = 1,
  parameter gate_func_e GATE_FUNC     = GF_NOR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  if (N_IN < 1 || N_IN > MAX_IN) begin : g_bad_n
    $error("N_IN must be in 1..6");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > MAX_SETTLE) begin : g_bad_s
    $error("SETTLE_CYCLES must be in 1..15");
  end

  state_e          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;
  logic [5:0]      vec6;
  logic            mism;

  always_comb begin
    vec6           = '0;
    vec6[N_IN-1:0] = stim_q;
  end

  assign mism = dut_out != expected_out(GATE_FUNC, vec6, N_IN);

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SETTLE;
          stim_d  = '0;
          cnt_d   = 4'd1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'(SETTLE_CYCLES)) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        err_d = err_q + (N_IN+1)'(mism);
        if (mism && !ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = stim_q;
        end
        // the last vector's own mismatch counts toward pass
        if (stim_q == '1) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_SETTLE;
          stim_d  = stim_q + 1'b1;
          cnt_d   = 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: two checker instances (NOR/2/1 and
// XOR/3/3) against bench gates with injectable faults.
module tb_gate_sweep_checker;
  import gate_check_pkg::*;

  typedef struct {
    int ch;
    int err;
    int ffv;
    int ffvec;
    int pas;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [1:0] stim_a;
  logic [2:0] stim_b;
  logic       out_a, out_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;
  logic       pass_a, pass_b;
  logic [2:0] err_a;
  logic [3:0] err_b;
  logic       ffv_a, ffv_b;
  logic [1:0] ffvec_a;
  logic [2:0] ffvec_b;
  logic [7:0] mask_a, mask_b;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  bit   active = 0;
  int   act_ch = 0;
  int   start_cyc = 0;
  bit   dprev[2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nin(int c);
    return (c == 0) ? 2 : 3;
  endfunction

  function automatic int sc(int c);
    return (c == 0) ? 1 : 3;
  endfunction

  // ch0 gate: 2-input NOR; ch1 gate: 3-input XOR
  function automatic logic ref_out(int c, int v);
    if (c == 0) return (v % 4) == 0;
    return ($countones(v % 8) % 2) == 1;
  endfunction

  function automatic exp_t model(int c, logic [7:0] m);
    exp_t e;
    e.ch = c;
    e.err = 0;
    e.ffv = 0;
    e.ffvec = 0;
    for (int i = 0; i < (1 << nin(c)); i++) begin
      if (m[i]) begin
        if (e.ffv == 0) e.ffvec = i;
        e.ffv = 1;
        e.err++;
      end
    end
    e.pas = (e.err == 0);
    e.lat = (1 << nin(c)) * (sc(c) + 1);
    return e;
  endfunction

  function automatic logic [7:0] stuck_mask(int c, logic val);
    logic [7:0] m = '0;
    for (int i = 0; i < (1 << nin(c)); i++)
      m[i] = ref_out(c, i) != val;
    return m;
  endfunction

  function automatic void chk(string nm, int c, int got, int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %0d, want %0d",
               nm, c, got, want);
    end
  endfunction

  assign out_a = ref_out(0, int'(stim_a)) ^ mask_a[stim_a];
  assign out_b = ref_out(1, int'(stim_b)) ^ mask_b[stim_b];

  gate_sweep_checker u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .stim(stim_a), .dut_out(out_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
  );

  gate_sweep_checker #(
    .N_IN(3), .SETTLE_CYCLES(3), .GATE_FUNC(GF_XOR)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .stim(stim_b), .dut_out(out_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
  );

  // monitor: per-cycle sweep tracking plus scoreboard pop
  always @(negedge clk) begin
    int st, bz, dn, ps, er, fv, fvec, k;
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        st = stim_a; bz = busy_a; dn = done_a;
        ps = pass_a; er = err_a; fv = ffv_a;
        fvec = ffvec_a;
      end else begin
        st = stim_b; bz = busy_b; dn = done_b;
        ps = pass_b; er = err_b; fv = ffv_b;
        fvec = ffvec_b;
      end
      k = cyc - start_cyc;
      if (active && act_ch == c) begin
        if (k == 0) begin
          chk("accept_err", c, er, 0);
          chk("accept_ffv", c, fv, 0);
          chk("accept_done", c, dn, 0);
        end
        if (k < (1 << nin(c)) * (sc(c) + 1)) begin
          chk("stim_seq", c, st, k / (sc(c) + 1));
          chk("busy_mid", c, bz, 1);
        end
      end
      if (dn != 0 && !dprev[c]) begin
        if (!active || act_ch != c || sbq.size() == 0) begin
          chk("unexpected_done", c, dn, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_channel", c, c, e.ch);
          chk("err_count", c, er, e.err);
          chk("ff_valid", c, fv, e.ffv);
          chk("ff_vec", c, fvec, e.ffvec);
          chk("pass", c, ps, e.pas);
          chk("latency", c, k, e.lat);
          chk("busy_end", c, bz, 0);
          active = 0;
        end
      end
      dprev[c] = (dn != 0);
    end
  end

  // called at posedge+2; returns at posedge+2 after accept edge
  task automatic issue_start(int c, logic [7:0] m);
    if (c == 0) begin
      mask_a = m; start_a = 1'b1;
    end else begin
      mask_b = m; start_b = 1'b1;
    end
    @(posedge clk);
    #1;
    start_cyc = cyc;
    act_ch = c;
    active = 1;
    sbq.push_back(model(c, m));
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (active && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (active) begin
      chk("done_timeout", act_ch, 0, 1);
      active = 0;
      sbq.delete();
    end
  endtask

  task automatic sweep(int c, logic [7:0] m);
    issue_start(c, m);
    wait_done();
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mask_a = '0;
    mask_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stim", 0, stim_a, 0);
    chk("rst_busy", 0, busy_a, 0);
    chk("rst_done", 0, done_a, 0);
    chk("rst_pass", 0, pass_a, 0);
    chk("rst_err", 0, err_a, 0);
    chk("rst_ffv", 0, ffv_a, 0);
    chk("rst_ffvec", 0, ffvec_a, 0);
    chk("rst_stim", 1, stim_b, 0);
    chk("rst_done", 1, done_b, 0);
    chk("rst_err", 1, err_b, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;

    sweep(0, 8'h00);
    sweep(0, stuck_mask(0, 1'b0));
    sweep(0, stuck_mask(0, 1'b1));
    sweep(0, 8'h00);

    // start during vector 10 settle, then reset in its sample
    issue_start(0, 8'h00);
    repeat (4) @(posedge clk);
    #2 start_a = 1'b1;
    @(posedge clk);
    #2 start_a = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    active = 0;
    sbq.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 0, busy_a, 0);
    chk("abort_done", 0, done_a, 0);
    chk("abort_stim", 0, stim_a, 0);
    chk("abort_err", 0, err_a, 0);
    @(posedge clk);
    #2;
    sweep(0, 8'h00);

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 3) == 0) sweep(0, 8'h00);
      else sweep(0, 8'($urandom_range(0, 15)));
    end

    sweep(1, 8'h00);
    sweep(1, 8'h20);
    sweep(1, 8'h00);
    for (int i = 0; i < 4; i++)
      sweep(1, 8'($urandom_range(0, 255)));

    repeat (3) @(posedge clk);
    chk("sb_drained", 0, sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Self-checking exhaustive stimulus/response stage for small combinational gate blocks. It drives every input vector, 0 to 2^N_IN-1 in ascending order, into the gate under test and samples the gate output after a programmable settle time. Each sample is compared against a built-in reference function, and the block accumulates a mismatch count and captures the first failing vector. It replaces hand-written loop benches and can be instantiated both in simulation and on-chip next to a gate.

Parameters:
N_IN, 2, number of gate inputs; legal range 1..6.
SETTLE_CYCLES, 1, cycles the stimulus is held before sampling; legal range 1..15; 0 is an elaboration error.
GATE_FUNC, GF_NOR, reference function applied across all stim bits; type gate_func_e.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
start  in  1  single-cycle sweep request
stim  out  N_IN  vector driven to the gate under test
dut_out  in  1  gate output being checked
busy  out  1  high while a sweep is in progress
done  out  1  high from the end of a sweep until the next accepted start or reset
pass  out  1  valid when done=1; 1 iff err_count==0
err_count  out  N_IN+1  number of mismatching vectors
first_fail_valid  out  1  at least one mismatch has been captured
first_fail_vec  out  N_IN  stim value at the first mismatch

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-low on rst_n. All state updates on the rising edge.
- Reset values: state=IDLE; stim, busy, done, pass, err_count, first_fail_valid and first_fail_vec are all 0. Reset takes priority over every other input.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 moves the FSM to SETTLE.
  - On the same edge: stim=0, settle counter=1, busy=1, err_count=0, first_fail_valid=0, first_fail_vec=0.
- SETTLE:
  - stim is held constant.
  - When the counter reaches SETTLE_CYCLES, go to SAMPLE; otherwise increment the counter.
- SAMPLE (exactly one cycle, stim still held):
  - expected = expected_out(GATE_FUNC, stim).
  - On mismatch: err_count increments. If first_fail_valid=0, set first_fail_vec=stim and first_fail_valid=1.
  - If stim == all-ones, go to DONE: busy=0, done=1, pass=(final err_count==0), with the mismatch in this cycle included.
  - Otherwise stim=stim+1, counter=1, go to SETTLE.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. If start is sampled at edge t, done first reads 1 after edge t + 2^N_IN*(SETTLE_CYCLES+1). For the defaults that is t+8.
- DONE:
  - All result outputs and stim are held.
  - start=1 behaves exactly as start in IDLE: it clears the results, drops done, and begins a new sweep.
- start during SETTLE/SAMPLE is ignored. No queuing.
- err_count is N_IN+1 bits wide, so the maximum value 2^N_IN fits without saturation.
- stim never wraps. The sweep terminates at all-ones.
- dut_out is sampled with no synchronizer; the gate under test shares clk.
- Reset mid-sweep: outputs equal their reset values on the next cycle. A following start runs a complete, fresh sweep.

Decomposition:
- Package gate_check_pkg contains:
  - typedef enum gate_func_e: GF_NOR, GF_OR, GF_NAND, GF_AND, GF_XOR, GF_XNOR.
  - typedef enum state_e for the FSM.
  - function expected_out(gate_func_e f, logic [5:0] v, int n), a reduction over the low n bits.
- No sub-module. The reference model is the package function, so the RTL stays in a single module.

Test Plan:
- Golden NOR, defaults: a NOR gate is wired stim→dut_out and start is pulsed at t. Required: stim steps 00,01,10,11 for 2 cycles each; done=1 after t+8; pass=1; err_count=0; first_fail_valid=0.
- Stuck-at-0 dut_out, NOR: required err_count=1, first_fail_vec=00, pass=0.
- Stuck-at-1 dut_out, NOR: required err_count=3, first_fail_vec=01, pass=0, first_fail_valid=1.
- start pulsed during the vector-10 SETTLE, then rst_n=0 for one cycle during vector 10: the start pulse has no effect. One cycle after reset, busy=0, done=0, stim=00. A new start yields a full 8-cycle sweep with correct results.
- N_IN=3, SETTLE_CYCLES=3, GATE_FUNC=GF_XOR, with a golden XOR DUT: done after t+32, pass=1. Inverting dut_out on vector 101 gives err_count=1 and first_fail_vec=101.
- Restart from DONE with a failing prior result: start clears err_count, first_fail_valid and done on the accept edge. A golden rerun ends with pass=1.
